// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the write/read FSM state encodings.
package axi4lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ARB, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ARB, R_DATA, R_RESP} rd_state_t;

endpackage

// File: rtl/axi4lite_extmem_arb_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R) between a master and the external-memory slave.
interface axi4lite_extmem_arb_if #(
  parameter int DATA_BITS = 64,
  parameter int ADDR_BITS = 32
);

  logic                   aw_valid;
  logic                   aw_ready;
  logic [ADDR_BITS-1:0]   aw_addr;
  logic [2:0]             aw_prot;
  logic                   w_valid;
  logic                   w_ready;
  logic [DATA_BITS-1:0]   w_data;
  logic [DATA_BITS/8-1:0] w_strb;
  logic                   b_valid;
  logic                   b_ready;
  logic [1:0]             b_resp;
  logic                   ar_valid;
  logic                   ar_ready;
  logic [ADDR_BITS-1:0]   ar_addr;
  logic [2:0]             ar_prot;
  logic                   r_valid;
  logic                   r_ready;
  logic [DATA_BITS-1:0]   r_data;
  logic [1:0]             r_resp;

  modport slave (
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport master (
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

endinterface

// File: rtl/extmem_sram_1p.sv
// Single-port byte-writable SRAM with 1-cycle synchronous read; rdata holds between reads.
module extmem_sram_1p #(
  parameter int DATA_BITS      = 64,
  parameter int MEM_WORDS_LOG2 = 20
) (
  input  logic                      clk,
  input  logic                      en,
  input  logic                      we,
  input  logic [DATA_BITS/8-1:0]    byte_en,
  input  logic [MEM_WORDS_LOG2-1:0] addr,
  input  logic [DATA_BITS-1:0]      wdata,
  output logic [DATA_BITS-1:0]      rdata
);

  logic [DATA_BITS-1:0] mem [2**MEM_WORDS_LOG2];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < DATA_BITS/8; b++) begin
          if (byte_en[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/axi4lite_extmem_arb.sv
// AXI4-Lite slave over one single-ported SRAM; reads and writes share the port round-robin.
// Optional macro AXI4LITE_EXTMEM_DECERR_EN: out-of-range addresses answer DECERR without an access.
module axi4lite_extmem_arb
  import axi4lite_pkg::*;
#(
  parameter int                   DATA_BITS      = 64,
  parameter int                   ADDR_BITS      = 32,
  parameter int                   MEM_WORDS_LOG2 = 20,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR      = '0
) (
  input logic                  clk,
  input logic                  rstn,
  axi4lite_extmem_arb_if.slave s_axi4lite
);

  localparam int STRB_BITS = DATA_BITS / 8;
  localparam int OFF       = $clog2(STRB_BITS);

  function automatic logic [MEM_WORDS_LOG2-1:0] word_idx(input logic [ADDR_BITS-1:0] addr);
    return MEM_WORDS_LOG2'((addr - BASE_ADDR) >> OFF);
  endfunction

`ifdef AXI4LITE_EXTMEM_DECERR_EN
  function automatic logic addr_err(input logic [ADDR_BITS-1:0] addr);
    logic [ADDR_BITS-1:0] rel;
    rel = addr - BASE_ADDR;
    return (addr < BASE_ADDR) || ((rel >> (MEM_WORDS_LOG2 + OFF)) != '0);
  endfunction
`endif

  wr_state_t                 wr_state_q, wr_state_d;
  rd_state_t                 rd_state_q, rd_state_d;
  logic                      init_q;
  logic                      last_rd_q;
  logic                      aw_full_q, aw_full_d;
  logic                      w_full_q, w_full_d;
  logic                      aw_fire, w_fire, ar_fire;
  logic                      wr_req, rd_req, grant_w, grant_r;
  logic                      wr_err, rd_err;
  logic [ADDR_BITS-1:0]      aw_addr_q, ar_addr_q;
  logic [DATA_BITS-1:0]      w_data_q;
  logic [STRB_BITS-1:0]      w_strb_q;
  logic [MEM_WORDS_LOG2-1:0] sram_addr;
  logic [DATA_BITS-1:0]      sram_rdata;
  logic [DATA_BITS-1:0]      r_data_p2;
  logic                      unused_prot;

  assign unused_prot = ^{s_axi4lite.aw_prot, s_axi4lite.ar_prot};

`ifdef AXI4LITE_EXTMEM_DECERR_EN
  assign wr_err = addr_err(aw_addr_q);
  assign rd_err = addr_err(ar_addr_q);
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  // Handshakes stay closed during reset and for the first cycle after it.
  assign s_axi4lite.aw_ready = rstn && init_q && (wr_state_q == W_IDLE) && !aw_full_q;
  assign s_axi4lite.w_ready  = rstn && init_q && (wr_state_q == W_IDLE) && !w_full_q;
  assign s_axi4lite.ar_ready = rstn && init_q && (rd_state_q == R_IDLE);
  assign s_axi4lite.b_valid  = rstn && (wr_state_q == W_RESP);
  assign s_axi4lite.r_valid  = rstn && (rd_state_q == R_RESP);
  assign s_axi4lite.b_resp   = (s_axi4lite.b_valid && wr_err) ? DECERR : OKAY;
  assign s_axi4lite.r_resp   = (s_axi4lite.r_valid && rd_err) ? DECERR : OKAY;
  assign s_axi4lite.r_data   = rstn ? r_data_p2 : '0;

  assign aw_fire = s_axi4lite.aw_valid && s_axi4lite.aw_ready;
  assign w_fire  = s_axi4lite.w_valid  && s_axi4lite.w_ready;
  assign ar_fire = s_axi4lite.ar_valid && s_axi4lite.ar_ready;

  // p0: round-robin arbitration for the single SRAM port
  assign wr_req    = rstn && (wr_state_q == W_ARB) && !wr_err;
  assign rd_req    = rstn && (rd_state_q == R_ARB) && !rd_err;
  assign grant_w   = wr_req && (!rd_req || last_rd_q);
  assign grant_r   = rd_req && (!wr_req || !last_rd_q);
  assign sram_addr = grant_w ? word_idx(aw_addr_q) : word_idx(ar_addr_q);

  extmem_sram_1p #(
    .DATA_BITS      (DATA_BITS),
    .MEM_WORDS_LOG2 (MEM_WORDS_LOG2)
  ) u_sram (
    .clk     (clk),
    .en      (grant_w || grant_r),
    .we      (grant_w),
    .byte_en (w_strb_q),
    .addr    (sram_addr),
    .wdata   (w_data_q),
    .rdata   (sram_rdata)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    aw_full_d  = aw_full_q || aw_fire;
    w_full_d   = w_full_q || w_fire;
    unique case (wr_state_q)
      W_IDLE: if (aw_full_d && w_full_d) wr_state_d = W_ARB;
      W_ARB:  if (grant_w || wr_err) wr_state_d = W_RESP;
      W_RESP: begin
        if (s_axi4lite.b_ready) begin
          wr_state_d = W_IDLE;
          aw_full_d  = 1'b0;
          w_full_d   = 1'b0;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      R_IDLE: if (ar_fire) rd_state_d = R_ARB;
      R_ARB: begin
        if (rd_err)       rd_state_d = R_RESP;
        else if (grant_r) rd_state_d = R_DATA;
      end
      R_DATA: rd_state_d = R_RESP;
      R_RESP: if (s_axi4lite.r_ready) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      init_q     <= 1'b0;
      last_rd_q  <= 1'b1;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_full_q  <= aw_full_d;
      w_full_q   <= w_full_d;
      init_q     <= 1'b1;
      if (grant_w)      last_rd_q <= 1'b0;
      else if (grant_r) last_rd_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_fire) aw_addr_q <= s_axi4lite.aw_addr;
    if (w_fire) begin
      w_data_q <= s_axi4lite.w_data;
      w_strb_q <= s_axi4lite.w_strb;
    end
    if (ar_fire) ar_addr_q <= s_axi4lite.ar_addr;
  end

  // p2: SRAM output is valid in R_DATA and is held here until the R handshake
  always_ff @(posedge clk) begin
    if (!rstn)                               r_data_p2 <= '0;
    else if (rd_state_q == R_DATA)           r_data_p2 <= sram_rdata;
    else if (rd_state_q == R_ARB && rd_err)  r_data_p2 <= '0;
  end

endmodule

// File: tb/tb_axi4lite_extmem_arb.sv
// Self-checking bench for axi4lite_extmem_arb: vector table plus hand sequences, with per-channel scoreboards.
module tb_axi4lite_extmem_arb;

  logic clk = 1'b0;
  logic rstn;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    int          lat;
  } exp_t;

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    int          d0;
    int          d1;
    logic [1:0]  resp;
    int          lat;
  } vec_t;

  exp_t wq[$];
  exp_t rq[$];
  vec_t vec[11];

  axi4lite_extmem_arb_if #(.DATA_BITS(64), .ADDR_BITS(32)) bus ();

  axi4lite_extmem_arb #(
    .DATA_BITS      (64),
    .ADDR_BITS      (32),
    .MEM_WORDS_LOG2 (12),
    .BASE_ADDR      (32'h0)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_axi4lite (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_aw(input logic [31:0] a, input int dly);
    repeat (dly) @(negedge clk);
    bus.aw_addr  = a;
    bus.aw_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.aw_ready; i++) @(negedge clk);
    check("aw_handshake", bus.aw_ready, 1);
    @(negedge clk);
    bus.aw_valid = 1'b0;
  endtask

  task automatic drive_w(input logic [63:0] d, input logic [7:0] s, input int dly);
    repeat (dly) @(negedge clk);
    bus.w_data  = d;
    bus.w_strb  = s;
    bus.w_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.w_ready; i++) @(negedge clk);
    check("w_handshake", bus.w_ready, 1);
    @(negedge clk);
    bus.w_valid = 1'b0;
  endtask

  task automatic drive_ar(input logic [31:0] a, input int dly);
    repeat (dly) @(negedge clk);
    bus.ar_addr  = a;
    bus.ar_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.ar_ready; i++) @(negedge clk);
    check("ar_handshake", bus.ar_ready, 1);
    @(negedge clk);
    bus.ar_valid = 1'b0;
  endtask

  task automatic wait_b(input int start, input int hold);
    exp_t e;
    for (int n = 0; n < 100 && !bus.b_valid; n++) @(negedge clk);
    if (!bus.b_valid) begin
      check("b_timeout", 0, 1);
      return;
    end
    e = wq.pop_front();
    check("b_latency", cyc - start, e.lat);
    check("b_resp", bus.b_resp, e.resp);
    repeat (hold) begin
      @(negedge clk);
      check("b_hold_valid", bus.b_valid, 1);
      check("b_hold_aw_ready", bus.aw_ready, 0);
      check("b_hold_w_ready", bus.w_ready, 0);
    end
    bus.b_ready = 1'b1;
    @(negedge clk);
    bus.b_ready = 1'b0;
    check("b_done", bus.b_valid, 0);
  endtask

  task automatic wait_r(input int start, input int hold);
    exp_t e;
    for (int n = 0; n < 100 && !bus.r_valid; n++) @(negedge clk);
    if (!bus.r_valid) begin
      check("r_timeout", 0, 1);
      return;
    end
    e = rq.pop_front();
    check("r_latency", cyc - start, e.lat);
    check("r_data", bus.r_data, e.data);
    check("r_resp", bus.r_resp, e.resp);
    repeat (hold) begin
      @(negedge clk);
      check("r_hold_valid", bus.r_valid, 1);
      check("r_hold_data", bus.r_data, e.data);
      check("r_hold_ar_ready", bus.ar_ready, 0);
    end
    bus.r_ready = 1'b1;
    @(negedge clk);
    bus.r_ready = 1'b0;
    check("r_done", bus.r_valid, 0);
    check("ar_ready_after_r", bus.ar_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_aw_ready"}, bus.aw_ready, 0);
    check({tag, "_w_ready"}, bus.w_ready, 0);
    check({tag, "_ar_ready"}, bus.ar_ready, 0);
    check({tag, "_b_valid"}, bus.b_valid, 0);
    check({tag, "_r_valid"}, bus.r_valid, 0);
    check({tag, "_b_resp"}, bus.b_resp, 0);
    check({tag, "_r_resp"}, bus.r_resp, 0);
    check({tag, "_r_data"}, bus.r_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int start;

    vec[0]  = '{1'b0, 32'h0000_0040, 64'h1122334455667788, 8'hFF, 0, 0, 2'b00, 2};
    vec[1]  = '{1'b1, 32'h0000_0040, 64'h1122334455667788, 8'h00, 0, 0, 2'b00, 3};
    vec[2]  = '{1'b0, 32'h0000_0048, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0, 3, 2'b00, 5};
    vec[3]  = '{1'b0, 32'h0000_0048, 64'hA5A5A5A50BADF00D, 8'h0F, 4, 0, 2'b00, 6};
    vec[4]  = '{1'b1, 32'h0000_0048, 64'hFFFFFFFF0BADF00D, 8'h00, 0, 0, 2'b00, 3};
    vec[5]  = '{1'b0, 32'h0000_0000, 64'h0123456789ABCDEF, 8'hFF, 0, 0, 2'b00, 2};
    vec[6]  = '{1'b0, 32'h0000_0000, 64'hFFEEDDCCBBAA9988, 8'h81, 1, 1, 2'b00, 3};
    vec[7]  = '{1'b1, 32'h0000_0005, 64'hFF23456789ABCD88, 8'h00, 0, 0, 2'b00, 3};
`ifdef AXI4LITE_EXTMEM_DECERR_EN
    vec[8]  = '{1'b1, 32'h0000_8000, 64'h0,                8'h00, 0, 0, 2'b11, 2};
`else
    vec[8]  = '{1'b1, 32'h0000_8000, 64'hFF23456789ABCD88, 8'h00, 0, 0, 2'b00, 3};
`endif
    vec[9]  = '{1'b0, 32'h0000_7FF8, 64'h5555AAAA5555AAAA, 8'hFF, 2, 2, 2'b00, 4};
    vec[10] = '{1'b1, 32'h0000_7FF8, 64'h5555AAAA5555AAAA, 8'h00, 1, 0, 2'b00, 4};

    rstn         = 1'b0;
    bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.aw_prot = '0;
    bus.w_valid  = 1'b0; bus.w_data  = '0; bus.w_strb  = '0;
    bus.b_ready  = 1'b0;
    bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.ar_prot = '0;
    bus.r_ready  = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    #1;
    check("post_reset_aw_ready", bus.aw_ready, 0);
    check("post_reset_w_ready", bus.w_ready, 0);
    check("post_reset_ar_ready", bus.ar_ready, 0);
    @(negedge clk);
    check("ready_aw_after_reset", bus.aw_ready, 1);

    // Simultaneous write and read to the same word: write wins, read sees new data.
    start = cyc;
    wq.push_back('{64'h0, 2'b00, 2});
    rq.push_back('{64'h0F1E2D3C4B5A6978, 2'b00, 4});
    fork
      drive_aw(32'h80, 0);
      drive_w(64'h0F1E2D3C4B5A6978, 8'hFF, 0);
      drive_ar(32'h80, 0);
    join
    fork
      wait_b(start, 0);
      wait_r(start, 0);
    join

    for (int i = 0; i < 11; i++) begin
      start = cyc;
      if (vec[i].is_rd) begin
        rq.push_back('{vec[i].data, vec[i].resp, vec[i].lat});
        drive_ar(vec[i].addr, vec[i].d0);
        wait_r(start, 0);
      end else begin
        wq.push_back('{64'h0, vec[i].resp, vec[i].lat});
        fork
          drive_aw(vec[i].addr, vec[i].d0);
          drive_w(vec[i].data, vec[i].strb, vec[i].d1);
        join
        wait_b(start, 0);
      end
    end

    // Back-pressure on B and R.
    start = cyc;
    wq.push_back('{64'h0, 2'b00, 2});
    fork
      drive_aw(32'h90, 0);
      drive_w(64'h0102030405060708, 8'hFF, 0);
    join
    wait_b(start, 10);
    start = cyc;
    rq.push_back('{64'h0102030405060708, 2'b00, 3});
    drive_ar(32'h90, 0);
    wait_r(start, 6);

    // Reset while the read sits in R_ARB drops it; the next read completes normally.
    bus.ar_addr  = 32'h40;
    bus.ar_valid = 1'b1;
    check("ar_ready_before_reset", bus.ar_ready, 1);
    @(negedge clk);
    bus.ar_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check("mid_reset_ar_ready", bus.ar_ready, 0);
    check("mid_reset_r_valid", bus.r_valid, 0);
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs("mid_reset");
    end
    rstn = 1'b1;
    #1;
    check("rerelease_ar_ready", bus.ar_ready, 0);
    @(negedge clk);
    check("dropped_r_valid", bus.r_valid, 0);
    check("rerelease_ar_ready_open", bus.ar_ready, 1);
    start = cyc;
    rq.push_back('{64'h1122334455667788, 2'b00, 3});
    drive_ar(32'h40, 0);
    wait_r(start, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4lite_extmem_arb.md
# axi4lite_extmem_arb

AXI4-Lite slave wrapping one truly single-ported, byte-writable SRAM, parametrised in data width, depth and base address. It is the next-generation external-memory model for the AXI4 bridge test environment. It accepts AW and W in either order and fully honours B/R back-pressure. Reads and writes compete for the one SRAM port through a round-robin arbiter.

## Interface
Parameters:
- DATA_BITS, 64, bus/word width; 32 or 64; STRB_BITS = DATA_BITS/8
- ADDR_BITS, 32, AXI address width
- MEM_WORDS_LOG2, 20, log2 of word count
- BASE_ADDR, 0, byte address of word 0; aligned to memory size

Ports (AXI signals prefixed s_axi4lite_):
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset; **synchronous, active-low**
- aw_valid/aw_ready  in/out  1  write address handshake; aw_addr in ADDR_BITS; aw_prot in 3 (ignored)
- w_valid/w_ready  in/out  1  write data handshake; w_data in DATA_BITS; w_strb in STRB_BITS
- b_valid/b_ready  out/in  1  write response; b_resp out 2
- ar_valid/ar_ready  in/out  1  read address; ar_addr in ADDR_BITS; ar_prot in 3 (ignored)
- r_valid/r_ready  out/in  1  read data; r_data out DATA_BITS; r_resp out 2

## Operation
- OFF = log2(STRB_BITS); word index = (addr − BASE_ADDR)[MEM_WORDS_LOG2+OFF−1:OFF]; low OFF bits ignored.
- Write FSM W_IDLE → W_ARB → W_RESP → W_IDLE.
  - In W_IDLE, AW and W are each captured into a one-entry holding register; each ready = its register empty.
  - Order is free: both in the same cycle, or either one first.
  - When both registers are full, go to W_ARB. Hold there until granted; the SRAM write uses w_strb byte enables.
  - Then go to W_RESP: b_valid=1 until b_ready; then clear both registers and return to W_IDLE.
- Read FSM R_IDLE → R_ARB → R_DATA → R_RESP → R_IDLE.
  - ar_ready=1 only in R_IDLE. A fired AR captures the address and goes to R_ARB, where it waits for the grant.
  - R_DATA is the cycle in which SRAM output is valid; r_data is registered there.
  - R_RESP: r_valid=1, r_data/r_resp stable until r_ready.
- Arbiter: one SRAM access per cycle. A lone requester is granted the same cycle. When W_ARB and R_ARB request together, the grant goes to the class not granted last; the last-grant flag resets to "read", so write wins first.
- Responses: OKAY (2'b00) unless the macro below applies.
- Outputs while rstn=0 and one cycle after: all readies 0, b_valid=0, r_valid=0, resps=0, r_data=0. Reset mid-transaction drops it silently.

## Timing
- Write, no contention, AW+W at cycle 0 → SRAM write cycle 1 → b_valid cycle 2. AW at cycle 0 and W at cycle 3 → b_valid at cycle 5.
- Read, no contention, AR at cycle 0 → SRAM read cycle 1 → capture cycle 2 → r_valid cycle 3.
- Each loss of arbitration adds 1 cycle.
- A write granted before a read to the same word is visible to that read. A read granted first returns the old data.
- Next AR is accepted only in the cycle after r_ready handshake; same for AW/W after b handshake. There is no pipelining; one outstanding per direction.

## Configuration
- AXI4LITE_EXTMEM_DECERR_EN defined:
  - An address with (addr − BASE_ADDR) ≥ 2^(MEM_WORDS_LOG2+OFF), or addr < BASE_ADDR, makes no SRAM access and skips arbitration.
  - That transaction responds DECERR (2'b11) one cycle after capture; r_data=0.
- Undefined: upper bits are ignored, the address wraps modulo memory size, and resp is always OKAY.

## Structure
- Shared package axi4lite_pkg: resp constants (OKAY, SLVERR, DECERR), wr_state_t, rd_state_t enums.
- Sub-module extmem_sram_1p: single port, en, we, byte_en[STRB_BITS], addr[MEM_WORDS_LOG2], wdata, rdata; 1-cycle synchronous read; rdata holds between reads.
- Arbiter and both FSMs live in the top module.

## Test plan
- Write 0x1122334455667788 to 0x40 with strb 0xFF, then read 0x40 → b_resp=0 at cycle 2; r_data=0x1122334455667788 at cycle 3 after AR.
- W at cycle 0, AW 0x48 at cycle 4, strb 0x0F over a word holding all-ones → b at cycle 6; readback 0xFFFFFFFF_xxxxxxxx with low bytes = written data.
- AW+W to 0x80 and AR to 0x80 in the same cycle after reset → write granted first; read returns the new data, r_valid at cycle 4.
- Hold b_ready=0 for 10 cycles → b_valid stays 1, aw_ready/w_ready stay 0. Hold r_ready=0 → r_data stable.
- Read 2^(MEM_WORDS_LOG2+OFF) + BASE_ADDR: with macro → r_resp=2'b11, r_data=0. Without → data of word 0.
- Deassert rstn while in R_ARB → r_valid=0 and ar_ready=0 during reset; the first AR after reset completes normally.
